// File: rtl/frame_checker_pkg.sv
// Shared constants for the frame checker and the upstream framing interface.
// Holds frame-type codes, confirmation codes, CRC-32 constants, byte offsets
// within a frame, and the one-hot state encoding of the checker FSM.
package frame_checker_pkg;

    // Frame type byte values
    localparam logic [7:0] FrmFirst  = 8'h00;
    localparam logic [7:0] FrmLast   = 8'h01;
    localparam logic [7:0] FrmNormal = 8'h02;
    localparam logic [7:0] FrmSingle = 8'h03;

    // Confirmation codes returned to the PC
    localparam logic [7:0] CodeOkay  = 8'h05;
    localparam logic [7:0] CodeError = 8'h04;
    localparam logic [7:0] CodeFatal = 8'h08;

    // CRC-32/IEEE, reflected form
    localparam logic [31:0] CrcPoly   = 32'hEDB88320;
    localparam logic [31:0] CrcInit   = 32'hFFFFFFFF;
    localparam logic [31:0] CrcXorOut = 32'hFFFFFFFF;

    // Byte offsets inside a frame
    localparam int unsigned OffType = 0;
    localparam int unsigned OffLen  = 1;
    localparam int unsigned OffNum  = 3;
    localparam int unsigned OffPay  = 7;
    localparam int unsigned OffCrc  = 71;

    typedef enum logic [5:0] {
        StIdle    = 6'b000001,
        StCrc     = 6'b000010,
        StCheck   = 6'b000100,
        StDeliver = 6'b001000,
        StConfirm = 6'b010000,
        StRearm   = 6'b100000
    } state_e;

endpackage

// File: rtl/crc32_byte.sv
// One-byte step of reflected CRC-32. Purely combinational.
// Ports:
//   crc_i  - running CRC register value
//   data_i - next message byte
//   crc_o  - CRC register value after absorbing data_i
module crc32_byte
    import frame_checker_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    always_comb begin
        crc_o = crc_i ^ {24'h000000, data_i};
        for (int i = 0; i < 8; i++) begin
            crc_o = crc_o[0] ? ((crc_o >> 1) ^ CrcPoly) : (crc_o >> 1);
        end
    end

endmodule

// File: rtl/frame_checker.sv
// Frame checker: validates a de-escaped frame (CRC-32, type, length, sequence
// number), offers accepted payloads downstream over valid/ready and returns a
// one-byte confirmation code.
// Ports:
//   clk, init_n          - clock, asynchronous active-low reset
//   fin, fin_valid       - frame from the framing interface (level valid)
//   confirm, conf_code   - one-cycle pulse with OKAY/ERROR/FATAL_ERROR code
//   pay_data/len/first/last, pay_valid, pay_ready - payload handshake
//   err_count            - saturating count of rejected frames
module frame_checker
    import frame_checker_pkg::*;
#(
    parameter int unsigned DATA_SIZE     = 64,
    parameter int unsigned PREAMBLE_SIZE = 7,
    parameter int unsigned CRC_SIZE      = 4,
    parameter int unsigned FRAME_SIZE    = (PREAMBLE_SIZE + DATA_SIZE + CRC_SIZE) * 8 - 1,
    parameter int unsigned MAX_ERR       = 3
) (
    input  logic                  clk,
    input  logic                  init_n,
    input  logic [0:FRAME_SIZE]   fin,
    input  logic                  fin_valid,
    output logic                  confirm,
    output logic [7:0]            conf_code,
    output logic [0:DATA_SIZE*8-1] pay_data,
    output logic [6:0]            pay_len,
    output logic                  pay_first,
    output logic                  pay_last,
    output logic                  pay_valid,
    input  logic                  pay_ready,
    output logic [7:0]            err_count
);

    localparam int unsigned       FrameBytes = (FRAME_SIZE + 1) / 8;
    localparam int unsigned       IdxW       = $clog2(FrameBytes);
    localparam logic [IdxW-1:0]   LastIdx    = IdxW'(OffCrc - 1);
    localparam logic [15:0]       MaxLen     = 16'(DATA_SIZE);
    localparam logic [7:0]        MaxErr     = 8'(MAX_ERR);

    state_e              state_q, state_d;
    logic [0:FRAME_SIZE] fin_q, fin_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [31:0]         crc_q, crc_d, crc_nxt;
    logic                session_q, session_d;
    logic [31:0]         expected_q, expected_d;
    logic [7:0]          cons_err_q, cons_err_d;
    logic [7:0]          err_count_q, err_count_d;
    logic [7:0]          conf_code_q, conf_code_d;
    logic                confirm_q, confirm_d;
    logic                pay_valid_q, pay_valid_d;

    // Header and trailer fields of the latched frame
    logic [7:0]  typ;
    logic [15:0] len;
    logic [31:0] num;
    logic [31:0] rx_crc;
    logic [7:0]  cur_byte;

    assign typ    = fin_q[OffType*8 +: 8];
    assign len    = {fin_q[OffLen*8 +: 8], fin_q[(OffLen+1)*8 +: 8]};
    assign num    = {fin_q[OffNum*8 +: 8], fin_q[(OffNum+1)*8 +: 8],
                     fin_q[(OffNum+2)*8 +: 8], fin_q[(OffNum+3)*8 +: 8]};
    assign rx_crc = {fin_q[OffCrc*8 +: 8], fin_q[(OffCrc+1)*8 +: 8],
                     fin_q[(OffCrc+2)*8 +: 8], fin_q[(OffCrc+3)*8 +: 8]};
    assign cur_byte = fin_q[{idx_q, 3'b000} +: 8];

    crc32_byte u_crc32_byte (
        .crc_i  (crc_q),
        .data_i (cur_byte),
        .crc_o  (crc_nxt)
    );

    // Checks in priority order; the first failing one decides the frame.
    logic crc_ok, type_ok, len_ok, in_session, sess_ok, num_ok, frame_ok;

    always_comb begin
        crc_ok     = ((crc_q ^ CrcXorOut) == rx_crc);
        type_ok    = (typ <= FrmSingle);
        len_ok     = (len != 16'd0) && (len <= MaxLen);
        in_session = (typ == FrmNormal) || (typ == FrmLast);
        sess_ok    = !in_session || session_q;
        num_ok     = !in_session || (num == expected_q);
        frame_ok   = crc_ok && type_ok && len_ok && sess_ok && num_ok;
    end

    logic handshake;
    assign handshake = (state_q == StDeliver) && pay_valid_q && pay_ready;

    always_comb begin
        state_d     = state_q;
        fin_d       = fin_q;
        idx_d       = idx_q;
        crc_d       = crc_q;
        session_d   = session_q;
        expected_d  = expected_q;
        cons_err_d  = cons_err_q;
        err_count_d = err_count_q;
        conf_code_d = conf_code_q;

        unique case (state_q)
            StIdle: begin
                if (fin_valid) begin
                    fin_d   = fin;
                    idx_d   = '0;
                    crc_d   = CrcInit;
                    state_d = StCrc;
                end
            end
            StCrc: begin
                crc_d = crc_nxt;
                idx_d = idx_q + 1'b1;
                if (idx_q == LastIdx) begin
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (frame_ok) begin
                    conf_code_d = CodeOkay;
                    cons_err_d  = '0;
                    if (typ == FrmFirst) begin
                        session_d  = 1'b1;
                        expected_d = num + 32'd1;
                    end else if (typ == FrmNormal) begin
                        expected_d = expected_q + 32'd1;
                    end else begin
                        session_d  = 1'b0;
                        expected_d = '0;
                    end
                    state_d = StDeliver;
                end else begin
                    if (err_count_q != 8'hFF) begin
                        err_count_d = err_count_q + 8'd1;
                    end
                    if (cons_err_q + 8'd1 >= MaxErr) begin
                        conf_code_d = CodeFatal;
                        cons_err_d  = '0;
                        session_d   = 1'b0;
                        expected_d  = '0;
                    end else begin
                        conf_code_d = CodeError;
                        cons_err_d  = cons_err_q + 8'd1;
                    end
                    state_d = StConfirm;
                end
            end
            StDeliver: begin
                // The confirm pulse is launched on the handshake edge itself,
                // so the FSM moves straight on to rearm.
                if (handshake) begin
                    state_d = StRearm;
                end
            end
            StConfirm: begin
                state_d = StRearm;
            end
            StRearm: begin
                if (!fin_valid) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Registered outputs: pay_valid rises one cycle after entering DELIVER
        // and drops only on the handshake edge.
        pay_valid_d = (state_q == StDeliver) && !handshake;
        confirm_d   = (state_q == StConfirm) || handshake;
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state_q     <= StIdle;
            fin_q       <= '0;
            idx_q       <= '0;
            crc_q       <= '0;
            session_q   <= 1'b0;
            expected_q  <= '0;
            cons_err_q  <= '0;
            err_count_q <= '0;
            conf_code_q <= '0;
            confirm_q   <= 1'b0;
            pay_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fin_q       <= fin_d;
            idx_q       <= idx_d;
            crc_q       <= crc_d;
            session_q   <= session_d;
            expected_q  <= expected_d;
            cons_err_q  <= cons_err_d;
            err_count_q <= err_count_d;
            conf_code_q <= conf_code_d;
            confirm_q   <= confirm_d;
            pay_valid_q <= pay_valid_d;
        end
    end

    // Payload fields are forced to zero whenever nothing is offered.
    assign pay_valid = pay_valid_q;
    assign pay_data  = pay_valid_q ? fin_q[OffPay*8 +: DATA_SIZE*8] : '0;
    assign pay_len   = pay_valid_q ? len[6:0] : '0;
    assign pay_first = pay_valid_q && ((typ == FrmFirst) || (typ == FrmSingle));
    assign pay_last  = pay_valid_q && ((typ == FrmLast) || (typ == FrmSingle));
    assign confirm   = confirm_q;
    assign conf_code = conf_code_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_frame_checker.sv
// Directed bench for frame_checker: builds frames with a bit-serial CRC-32
// reference, drives them and checks codes, payload, timing and counters.
module tb_frame_checker;

    localparam int unsigned FS = 599;
    typedef logic [0:FS] frame_t;

    logic          clk = 1'b0;
    logic          init_n;
    frame_t        fin;
    logic          fin_valid;
    logic          confirm;
    logic [7:0]    conf_code;
    logic [0:511]  pay_data;
    logic [6:0]    pay_len;
    logic          pay_first;
    logic          pay_last;
    logic          pay_valid;
    logic          pay_ready;
    logic [7:0]    err_count;

    int checks = 0;
    int errors = 0;
    int exp_err = 0;

    frame_checker dut (
        .clk       (clk),
        .init_n    (init_n),
        .fin       (fin),
        .fin_valid (fin_valid),
        .confirm   (confirm),
        .conf_code (conf_code),
        .pay_data  (pay_data),
        .pay_len   (pay_len),
        .pay_first (pay_first),
        .pay_last  (pay_last),
        .pay_valid (pay_valid),
        .pay_ready (pay_ready),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference CRC-32, one message bit per step, over bytes 0..70.
    function automatic logic [31:0] crc_ref(input frame_t f);
        logic [31:0] c;
        logic [7:0]  b;
        logic        fb;
        c = 32'hFFFFFFFF;
        for (int k = 0; k < 71; k++) begin
            b = f[k*8 +: 8];
            for (int i = 0; i < 8; i++) begin
                fb = c[0] ^ b[i];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return ~c;
    endfunction

    function automatic frame_t mk(input logic [7:0] typ, input logic [15:0] len,
                                  input logic [31:0] num, input logic [7:0] seed);
        frame_t      f;
        logic [31:0] c;
        f = '0;
        f[0 +: 8]  = typ;
        f[8 +: 8]  = len[15:8];
        f[16 +: 8] = len[7:0];
        f[24 +: 8] = num[31:24];
        f[32 +: 8] = num[23:16];
        f[40 +: 8] = num[15:8];
        f[48 +: 8] = num[7:0];
        for (int i = 0; i < 64; i++) f[(7+i)*8 +: 8] = seed + 8'(i);
        c = crc_ref(f);
        f[568 +: 8] = c[31:24];
        f[576 +: 8] = c[23:16];
        f[584 +: 8] = c[15:8];
        f[592 +: 8] = c[7:0];
        return f;
    endfunction

    task automatic watch_quiet(input string tag, input int n);
        bit ok;
        ok = 1'b1;
        repeat (n) begin
            @(posedge clk); #1;
            if (confirm || pay_valid) ok = 1'b0;
        end
        check_eq(tag, ok, 1'b1);
    endtask

    // hold: cycles pay_ready stays low once pay_valid is up (0 = tied high)
    // keep: leave fin_valid asserted after the confirm
    task automatic run_frame(input string tag, input frame_t f, input logic [7:0] code,
                             input logic ef, input logic el, input logic [6:0] elen,
                             input int hold, input bit keep);
        logic [0:511] saved;
        bit           stable;
        pay_ready = (hold == 0);
        @(negedge clk);
        fin       = f;
        fin_valid = 1'b1;
        @(posedge clk); #1;                      // E0
        repeat (72) @(posedge clk);
        #1;                                      // E72
        check_eq({tag, "_e72_quiet"}, {confirm, pay_valid}, 2'b00);
        @(posedge clk); #1;                      // E73
        if (code != 8'h05) begin
            check_eq({tag, "_confirm"}, confirm, 1'b1);
            check_eq({tag, "_code"}, conf_code, code);
            check_eq({tag, "_no_pay"}, pay_valid, 1'b0);
            if (exp_err < 255) exp_err++;
        end else begin
            check_eq({tag, "_pay_valid"}, pay_valid, 1'b1);
            check_eq({tag, "_no_confirm"}, confirm, 1'b0);
            check_eq({tag, "_flags"}, {pay_first, pay_last}, {ef, el});
            check_eq({tag, "_len"}, pay_len, elen);
            check_eq({tag, "_data"}, pay_data, f[56 +: 512]);
            saved = pay_data;
            if (hold > 0) begin
                stable = 1'b1;
                repeat (hold) begin
                    @(posedge clk); #1;
                    if (!pay_valid || confirm || pay_data !== saved) stable = 1'b0;
                end
                check_eq({tag, "_hold_stable"}, stable, 1'b1);
                @(negedge clk);
                pay_ready = 1'b1;
                @(posedge clk); #1;              // handshake edge
            end else begin
                @(posedge clk); #1;              // E74
            end
            check_eq({tag, "_confirm"}, {confirm, pay_valid}, 2'b10);
            check_eq({tag, "_code"}, conf_code, 8'h05);
        end
        check_eq({tag, "_err_count"}, err_count, 8'(exp_err));
        if (!keep) begin
            @(negedge clk);
            fin_valid = 1'b0;
        end
        @(posedge clk); #1;
        check_eq({tag, "_pulse_end"}, confirm, 1'b0);
    endtask

    frame_t f;

    initial begin
        init_n    = 1'b1;
        fin       = '0;
        fin_valid = 1'b0;
        pay_ready = 1'b1;
        #1 init_n = 1'b0;
        #2;
        check_eq("rst_outs", {confirm, pay_valid, pay_first, pay_last, pay_len}, '0);
        check_eq("rst_code", conf_code, 8'h00);
        check_eq("rst_data", pay_data, '0);
        check_eq("rst_errcnt", err_count, 8'h00);
        @(negedge clk);
        @(negedge clk);
        init_n = 1'b1;

        run_frame("single16", mk(8'h03, 16'd16, 32'd0, 8'h10), 8'h05, 1, 1, 7'd16, 0, 0);
        run_frame("first10", mk(8'h00, 16'd64, 32'd10, 8'h20), 8'h05, 1, 0, 7'd64, 0, 0);
        run_frame("normal11", mk(8'h02, 16'd5, 32'd11, 8'h30), 8'h05, 0, 0, 7'd5, 0, 0);
        run_frame("last12", mk(8'h01, 16'd1, 32'd12, 8'h40), 8'h05, 0, 1, 7'd1, 0, 0);
        f = mk(8'h02, 16'd8, 32'd13, 8'h50);
        f[592 +: 8] = f[592 +: 8] ^ 8'h01;
        run_frame("crc_flip", f, 8'h04, 0, 0, 7'd0, 0, 0);
        run_frame("normal13_nosess", mk(8'h02, 16'd8, 32'd13, 8'h50), 8'h04, 0, 0, 7'd0, 0, 0);
        run_frame("first100", mk(8'h00, 16'd8, 32'd100, 8'h60), 8'h05, 1, 0, 7'd8, 0, 0);
        run_frame("bad_type", mk(8'h07, 16'd8, 32'd101, 8'h70), 8'h04, 0, 0, 7'd0, 0, 0);
        run_frame("len_zero", mk(8'h00, 16'd0, 32'd5, 8'h80), 8'h04, 0, 0, 7'd0, 0, 0);
        run_frame("bad_num_fatal", mk(8'h02, 16'd8, 32'd150, 8'h90), 8'h08, 0, 0, 7'd0, 0, 0);
        // Would pass if the session survived the FATAL; FATAL again if the
        // consecutive counter was not cleared.
        run_frame("after_fatal", mk(8'h02, 16'd8, 32'd101, 8'hA0), 8'h04, 0, 0, 7'd0, 0, 0);
        run_frame("len65", mk(8'h03, 16'd65, 32'd0, 8'hB0), 8'h04, 0, 0, 7'd0, 0, 0);
        run_frame("first200", mk(8'h00, 16'd32, 32'd200, 8'hC0), 8'h05, 1, 0, 7'd32, 0, 0);
        run_frame("first300_restart", mk(8'h00, 16'd2, 32'd300, 8'hD0), 8'h05, 1, 0, 7'd2, 0, 0);
        run_frame("normal301", mk(8'h02, 16'd3, 32'd301, 8'hE0), 8'h05, 0, 0, 7'd3, 0, 0);
        run_frame("single_mid", mk(8'h03, 16'd64, 32'd5, 8'hF0), 8'h05, 1, 1, 7'd64, 0, 0);
        run_frame("last302_closed", mk(8'h01, 16'd4, 32'd302, 8'h01), 8'h04, 0, 0, 7'd0, 0, 0);

        // Backpressure, then fin_valid held: no second capture allowed.
        run_frame("hold20", mk(8'h03, 16'd40, 32'd9, 8'h33), 8'h05, 1, 1, 7'd40, 20, 1);
        watch_quiet("no_recapture", 100);
        @(negedge clk);
        fin_valid = 1'b0;
        repeat (2) @(posedge clk);

        // Reset in the middle of the CRC pass.
        @(negedge clk);
        fin       = mk(8'h03, 16'd8, 32'd1, 8'h44);
        fin_valid = 1'b1;
        repeat (30) @(posedge clk);
        @(negedge clk);
        init_n = 1'b0;
        #1;
        check_eq("midrst_outs", {confirm, pay_valid, pay_first, pay_last, pay_len}, '0);
        check_eq("midrst_code", conf_code, 8'h00);
        check_eq("midrst_errcnt", err_count, 8'h00);
        exp_err   = 0;
        fin_valid = 1'b0;
        @(negedge clk);
        init_n = 1'b1;
        watch_quiet("midrst_no_confirm", 100);
        run_frame("post_reset", mk(8'h03, 16'd12, 32'd2, 8'h55), 8'h05, 1, 1, 7'd12, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_checker.md
# frame_checker

- Sits directly downstream of the UART framing interface.
- Takes each de-escaped 75-byte frame that interface delivers.
- Checks CRC-32, frame type, payload length and sequence number.
- Returns a one-byte confirmation code for transmission to the PC, and hands accepted payloads to the downstream secure-processing stage over a valid/ready handshake.

## Interface
- `DATA_SIZE`, 64: payload bytes per frame.
- `PREAMBLE_SIZE`, 7: header bytes.
- `CRC_SIZE`, 4: trailer bytes.
- `FRAME_SIZE`, (PREAMBLE_SIZE+DATA_SIZE+CRC_SIZE)*8-1: MSB index of the frame vector.
- `MAX_ERR`, 3: consecutive errors that escalate to FATAL_ERROR.

Ports (clock and reset first):
- `clk` in 1: single clock.
- `init_n` in 1: asynchronous, active-low reset.
- `fin` in [0:FRAME_SIZE]: frame. Byte k is `fin[k*8+:8]`.
- `fin_valid` in 1: level, held by upstream until it sees `confirm`.
- `confirm` out 1: one-cycle pulse, `conf_code` valid.
- `conf_code` out 8: OKAY 8'h05, ERROR 8'h04, FATAL_ERROR 8'h08.
- `pay_data` out [0:DATA_SIZE*8-1]: payload bytes 7..70.
- `pay_len` out 7: payload length, 1..64.
- `pay_first` out 1: frame type FIRST or SINGLE.
- `pay_last` out 1: frame type LAST or SINGLE.
- `pay_valid` out 1: payload offered.
- `pay_ready` in 1: downstream accepts.
- `err_count` out 8: total rejected frames, saturating at 255.

## Operation
- Frame layout:
  - byte 0: type. FIRST 8'h00, LAST 8'h01, NORMAL 8'h02, SINGLE 8'h03.
  - bytes 1–2: length, big-endian.
  - bytes 3–6: frame number, big-endian.
  - bytes 7–70: payload.
  - bytes 71–74: CRC, big-endian.
- CRC: CRC-32/IEEE (reflected poly 32'hEDB88320, init 32'hFFFFFFFF, final XOR 32'hFFFFFFFF) over bytes 0..70, one byte per clock.
- States:
  - **IDLE**: on `fin_valid`=1, latch `fin`, clear the byte index, go to CRC.
  - **CRC**: process byte index 0..70. After byte 70, go to CHECK.
  - **CHECK**: evaluate checks in priority order. The first failure gives ERROR:
    1. CRC mismatch.
    2. Type > 8'h03.
    3. Length 0 or > DATA_SIZE.
    4. NORMAL/LAST while no session is open.
    5. NORMAL/LAST with number ≠ `expected`.
  - On pass, go to DELIVER. On fail, go to CONFIRM.
  - **DELIVER**: hold `pay_valid`=1 with stable `pay_*` until `pay_ready`=1, then go to CONFIRM with code OKAY.
  - **CONFIRM**: pulse `confirm` for one cycle, then go to REARM.
  - **REARM**: wait for `fin_valid`=0, then go to IDLE. This prevents a held level being counted twice.
- Session rules on OKAY:
  - FIRST: open session, `expected` = number+1.
  - NORMAL: `expected` += 1.
  - LAST/SINGLE: close session, `expected` = 0.
  - A FIRST or SINGLE arriving mid-session restarts the session; it is not an error.
- Error escalation:
  - ERROR increments the consecutive-error counter and `err_count` (saturating). Session state is unchanged.
  - When the consecutive count reaches MAX_ERR, the code sent is FATAL_ERROR instead. Then close the session and clear the consecutive counter.
  - OKAY clears the consecutive counter.
- Reset values: all outputs 0, `conf_code` 8'h00, state IDLE, session closed, `expected` 0, both counters 0.
- Reset asserted mid-operation: abort immediately. No `confirm` or `pay_valid` is emitted for the aborted frame.

## Timing
- Edge E0 samples `fin_valid`=1 in IDLE. CRC occupies E1..E71 and CHECK is E72.
- Error path: `confirm` is high in the cycle after E73.
- OK path:
  - `pay_valid` rises after E73.
  - `confirm` is high in the cycle after the handshake edge.
  - With `pay_ready` tied 1, `confirm` is high after E74.
- `pay_valid` never drops without `pay_ready`. `pay_*` is constant while `pay_valid`=1.
- `confirm` and `pay_valid` are never high in the same cycle.
- `fin` is ignored outside IDLE. Changes to `fin` after E0 have no effect.

## Structure
- Shared package holds:
  - frame-type, flag and confirmation-code constants (shared with the framing interface);
  - byte-offset constants: TYPE 0, LEN 1, NUM 3, PAY 7, CRC 71;
  - the state encoding, one-hot.
- One sub-module, `crc32_byte`: purely combinational, next CRC from (crc, byte).

## Test plan
- Valid SINGLE, length 16, correct CRC, `pay_ready`=1 → `pay_valid`, `pay_first`=`pay_last`=1, `pay_len`=16, then `confirm` with 8'h05 after E74; session stays closed.
- FIRST #10, NORMAL #11, LAST #12, all valid → three OKAYs with correct first/last flags. A following NORMAL #13 → ERROR (no session).
- NORMAL with CRC byte 74 flipped → ERROR 8'h04 after E73, no `pay_valid`, `err_count`=1.
- Three consecutive bad frames with MAX_ERR=3 → 8'h04, 8'h04, 8'h08; after the FATAL, the session is closed and the consecutive counter is 0.
- Valid frame with `pay_ready` held 0 for 20 cycles → `pay_valid` stays high with stable data, `confirm` follows the handshake by one cycle. `fin_valid` held high afterwards → no second capture until it drops.
- `init_n` pulsed low mid-CRC → all outputs 0 immediately, no `confirm`. The next valid SINGLE is processed normally.
